// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : time-multiplexed common-anode 7-segment scan controller
//                 with guard cycles, frame-boundary double buffering and
//                 leading-zero blanking.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int SLOT  = 50000,
  parameter int GUARD = 2
) (
  input  logic              iClk,
  input  logic              irst,
  input  logic              iEn,
  input  logic              iLoad,
  input  logic [4*NDIG-1:0] iData,
  input  logic              iLzb,
  output logic [3:0]        oBCD,
  output logic [NDIG-1:0]   oAn,
  output logic              oFrame,
  output logic              oPend
);

  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(SLOT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  state_e             state_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [4*NDIG-1:0]  shadow_q;
  logic [4*NDIG-1:0]  pend_q;

  logic [4*NDIG-1:0]  shadow_d;
  logic [IW-1:0]      idx_d;
  logic               start;
  logic               slot_end;
  logic               boundary;
  logic               apply;

  // Digit k is blanked when leading-zero blanking is on and digits k..NDIG-1
  // are all zero; digit 0 always shows.
  function automatic logic [3:0] digit_out(input logic [4*NDIG-1:0] s,
                                           input logic [IW-1:0]     k,
                                           input logic              lzb);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(k) && s[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    if (lzb && k != '0 && upper_zero) return 4'hF;
    return s[{k, 2'b00} +: 4];
  endfunction

  always_comb begin
    start    = (state_q == S_IDLE) && iEn;
    slot_end = (state_q == S_SHOW) && iEn && (cnt_q == CW'(SLOT - 1));
    boundary = slot_end && (idx_q == IW'(NDIG - 1));
    apply    = start || boundary;

    // A load coinciding with an application point bypasses the pending buffer.
    shadow_d = shadow_q;
    if (apply) begin
      if (iLoad)      shadow_d = iData;
      else if (oPend) shadow_d = pend_q;
    end

    idx_d = apply ? '0 : idx_q + IW'(1);
  end

  always_ff @(posedge iClk or posedge irst) begin
    if (irst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pend_q   <= '0;
      oBCD     <= 4'hF;
      oAn      <= '1;
      oFrame   <= 1'b0;
      oPend    <= 1'b0;
    end else begin
      oFrame   <= 1'b0;
      shadow_q <= shadow_d;

      if (iLoad && !apply) begin
        pend_q <= iData;
        oPend  <= 1'b1;
      end else if (apply) begin
        oPend  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          oAn  <= '1;
          oBCD <= 4'hF;
          if (iEn) begin
            state_q <= S_GUARD;
            idx_q   <= '0;
            cnt_q   <= '0;
            oBCD    <= digit_out(shadow_d, '0, iLzb);
          end
        end

        S_GUARD: begin
          if (!iEn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            oAn     <= '1;
            oBCD    <= 4'hF;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(GUARD - 1)) begin
              state_q <= S_SHOW;
              oAn     <= ~(NDIG'(1) << idx_q);
            end
          end
        end

        S_SHOW: begin
          if (!iEn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            oAn     <= '1;
            oBCD    <= 4'hF;
          end else if (slot_end) begin
            state_q <= S_GUARD;
            cnt_q   <= '0;
            idx_q   <= idx_d;
            oAn     <= '1;
            oBCD    <= digit_out(shadow_d, idx_d, iLzb);
            oFrame  <= boundary;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          oAn     <= '1;
          oBCD    <= 4'hF;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
